mux_select_arbiter: RTL and testbench

Two-requester round-robin arbiter that generates the select for a 2:1 data multiplexer. Two sources (A, B) each raise a request. The block grants exactly one at a time, drives the mux select to match, and enforces a maximum hold time so neither source can starve the other. It sits directly upstream of the 2x1 multiplexer and drives its select input S.

---
 rtl/mux_select_arbiter.sv | 91 +++++++++
 tb/tb_mux_select_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 data mux.
// Grants are bounded by HOLD_MAX cycles so neither source can starve the other.
module mux_select_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic rel,
  output logic S,
  gnt_a,
  output logic gnt_b,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;
  logic       s_d;
  logic       end_a, end_b;
  logic       enter;

  // Any single end cause is enough; a release coinciding with timeout is one event.
  assign end_a = rel | ~req_a | (cnt_q == HOLD_LAST);
  assign end_b = rel | ~req_b | (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_a && req_b)
          state_d = last_b_q ? GRANT_A : GRANT_B;
        else if (req_a)
          state_d = GRANT_A;
        else if (req_b)
          state_d = GRANT_B;
      end
      GRANT_A: if (end_a) state_d = req_b ? GRANT_B : IDLE;
      GRANT_B: if (end_b) state_d = req_a ? GRANT_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every move into a grant state is an entry: restart the hold count, record owner.
  always_comb begin
    enter    = (state_d != state_q) && (state_d != IDLE);
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    s_d      = S;
    if (enter) begin
      cnt_d    = 8'd0;
      last_b_d = (state_d == GRANT_B);
    end else if ((state_q != IDLE) && (cnt_q != HOLD_LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (state_d == GRANT_A)
      s_d = 1'b0;
    else if (state_d == GRANT_B)
      s_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      last_b_q <= 1'b1;
      S        <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      S        <= s_d;
      gnt_a    <= (state_d == GRANT_A);
      gnt_b    <= (state_d == GRANT_B);
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Bench for mux_select_arbiter: directed scenarios plus a long randomized run,
// all compared against an owner/cycles-held reference model.
module tb_mux_select_arbiter;
  localparam int HM = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic rel = 1'b0;
  logic S, gnt_a, gnt_b, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0=none, 1=A, 2=B; held counts cycles granted so far.
  int   m_owner, m_held, m_last;
  logic m_s;

  mux_select_arbiter #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .rel(rel),
    .S(S), .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = 0; m_held = 0; m_last = 2; m_s = 1'b0;
  endfunction

  function automatic void model_edge(bit ra, bit rb, bit rl);
    bit mine, other;
    if (m_owner == 0) begin
      if (ra && rb) m_owner = (m_last == 1) ? 2 : 1;
      else if (ra)  m_owner = 1;
      else if (rb)  m_owner = 2;
      if (m_owner != 0) begin m_held = 1; m_last = m_owner; end
    end else begin
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (rl || !mine || m_held >= HM) begin
        if (other) begin m_owner = 3 - m_owner; m_held = 1; m_last = m_owner; end
        else begin m_owner = 0; m_held = 0; end
      end else begin
        m_held++;
      end
    end
    if (m_owner == 1) m_s = 1'b0;
    else if (m_owner == 2) m_s = 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(req_a, req_b, rel);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if ({S, gnt_a, gnt_b, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_hold: got S/ga/gb/busy=%b expected 0000", {S, gnt_a, gnt_b, busy});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got busy=%b ga=%b gb=%b expected 000", busy, gnt_a, gnt_b);
    end
    req_b = 1'b1;
    step(); step();
    checks++;
    if (gnt_b !== 1'b1 || S !== 1'b1) begin
      errors++; $display("FAIL reset_pre_grant_b: got gb=%b S=%b expected 1 1", gnt_b, S);
    end
    #2; rst_n = 1'b0; #1;
    model_reset();
    checks++;
    if ({S, gnt_a, gnt_b, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_async_mid_grant: got S/ga/gb/busy=%b expected 0000", {S, gnt_a, gnt_b, busy});
    end
    req_b = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_after_release: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    req_a = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || S !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL single_grant_cyc%0d: got ga=%b gb=%b S=%b busy=%b expected 1 0 0 1", i, gnt_a, gnt_b, S, busy);
      end
    end
    rel = 1'b1;
    step();
    rel = 1'b0;
    checks++;
    if (busy !== 1'b0 || gnt_a !== 1'b0 || S !== 1'b0) begin
      errors++; $display("FAIL single_release_idle: got busy=%b ga=%b S=%b expected 0 0 0", busy, gnt_a, S);
    end
    req_a = 1'b0;
    step(); step();
  endtask

  task automatic test_contention();
    int handovers = 0;
    logic prev_s;
    rst_n = 1'b0; #1; model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    step();
    checks++;
    if (gnt_a !== 1'b1 || S !== 1'b0) begin
      errors++; $display("FAIL contention_first_a: got ga=%b S=%b expected 1 0", gnt_a, S);
    end
    prev_s = S;
    for (int i = 0; i < 24; i++) begin
      rel = (i % 3 == 2);
      step();
      rel = 1'b0;
      checks++;
      if (busy !== 1'b1 || gnt_a !== (m_owner == 1) || gnt_b !== (m_owner == 2) || S !== m_s) begin
        errors++; $display("FAIL contention_cyc%0d: got ga=%b gb=%b S=%b busy=%b expected %b %b %b 1",
                           i, gnt_a, gnt_b, S, busy, m_owner == 1, m_owner == 2, m_s);
      end
      if (S !== prev_s) handovers++;
      prev_s = S;
    end
    checks++;
    if (handovers != 8) begin
      errors++; $display("FAIL contention_handovers: got %0d expected 8", handovers);
    end
    req_a = 1'b0; req_b = 1'b0;
    step(); step();
  endtask

  task automatic test_timeout();
    int run = 0;
    req_b = 1'b1;
    step();
    while (gnt_b === 1'b1 && run < 50) begin
      run++;
      step();
    end
    checks++;
    if (run != HM) begin
      errors++; $display("FAIL timeout_len: got %0d cycles expected %0d", run, HM);
    end
    checks++;
    if (busy !== 1'b0 || S !== 1'b1) begin
      errors++; $display("FAIL timeout_idle_gap: got busy=%b S=%b expected 0 1", busy, S);
    end
    step();
    checks++;
    if (gnt_b !== 1'b1 || S !== 1'b1) begin
      errors++; $display("FAIL timeout_regrant: got gb=%b S=%b expected 1 1", gnt_b, S);
    end
    req_b = 1'b0;
    step(); step();
  endtask

  task automatic test_drop();
    req_a = 1'b1;
    step(); step();
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++; $display("FAIL drop_grant_a: got ga=%b expected 1", gnt_a);
    end
    req_a = 1'b0; req_b = 1'b1;
    step();
    checks++;
    if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || S !== 1'b1) begin
      errors++; $display("FAIL drop_handover: got ga=%b gb=%b S=%b expected 0 1 1", gnt_a, gnt_b, S);
    end
    req_b = 1'b0;
    step();
    rel = 1'b1;
    step();
    rel = 1'b0;
    checks++;
    if (busy !== 1'b0 || S !== 1'b1) begin
      errors++; $display("FAIL drop_release_in_idle: got busy=%b S=%b expected 0 1", busy, S);
    end
  endtask

  task automatic test_random();
    int run_a = 0, run_b = 0;
    for (int i = 0; i < 10000; i++) begin
      req_a = ($urandom_range(0, 3) != 0);
      req_b = ($urandom_range(0, 3) != 0);
      rel   = ($urandom_range(0, 7) == 0);
      step();
      run_a = gnt_a ? run_a + 1 : 0;
      run_b = gnt_b ? run_b + 1 : 0;
      checks++;
      if (gnt_a !== (m_owner == 1) || gnt_b !== (m_owner == 2) || busy !== (m_owner != 0) || S !== m_s) begin
        errors++; $display("FAIL random_model_cyc%0d: got ga=%b gb=%b busy=%b S=%b expected %b %b %b %b",
                           i, gnt_a, gnt_b, busy, S, m_owner == 1, m_owner == 2, m_owner != 0, m_s);
      end
      checks++;
      if ((gnt_a && gnt_b) || (busy && S !== gnt_b) || run_a > HM || run_b > HM) begin
        errors++; $display("FAIL random_invariant_cyc%0d: got ga=%b gb=%b S=%b busy=%b runs=%0d/%0d limit %0d",
                           i, gnt_a, gnt_b, S, busy, run_a, run_b, HM);
      end
    end
    req_a = 1'b0; req_b = 1'b0; rel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
